// File: rtl/herring_gpu_pkg.sv
// Shared register map, command codes, status bits and FSM state type
// for the Herring GPU command engine.
package herring_gpu_pkg;

   localparam logic [2:0] RS_COLOR = 3'd0;
   localparam logic [2:0] RS_X_LO  = 3'd1;
   localparam logic [2:0] RS_X_HI  = 3'd2;
   localparam logic [2:0] RS_Y_LO  = 3'd3;
   localparam logic [2:0] RS_Y_HI  = 3'd4;
   localparam logic [2:0] RS_W     = 3'd5;
   localparam logic [2:0] RS_H     = 3'd6;
   localparam logic [2:0] RS_CMD   = 3'd7;

   localparam logic [7:0] CMD_PLOT     = 8'h01;
   localparam logic [7:0] CMD_PLOT_INC = 8'h02;
   localparam logic [7:0] CMD_FILL     = 8'h03;
   localparam logic [7:0] CMD_CLEAR    = 8'h04;

   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DROPPED = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PIXEL = 2'd1,
      WALK  = 2'd2
   } state_t;

   // Codes outside this set are silently ignored by the engine.
   function automatic logic is_valid_cmd(input logic [7:0] code);
      return (code == CMD_PLOT) || (code == CMD_PLOT_INC) ||
             (code == CMD_FILL) || (code == CMD_CLEAR);
   endfunction

endpackage

// File: rtl/herring_gpu_cmd_if.sv
// CPU register bus plus framebuffer write port of the command engine.
// master = CPU/framebuffer side, slave = the engine.
interface herring_gpu_cmd_if #(
   parameter int unsigned X_WIDTH     = 10,
   parameter int unsigned Y_WIDTH     = 10,
   parameter int unsigned COLOR_WIDTH = 3
);
   logic [2:0]             RS;
   logic [7:0]             DATA;
   logic                   CE;
   logic                   RW;
   logic [7:0]             DATA_OUT;
   logic [X_WIDTH-1:0]     FB_X;
   logic [Y_WIDTH-1:0]     FB_Y;
   logic [COLOR_WIDTH-1:0] FB_COLOR;
   logic                   FB_WE;
   logic                   FB_READY;

   modport master (
      output RS, DATA, CE, RW, FB_READY,
      input  DATA_OUT, FB_X, FB_Y, FB_COLOR, FB_WE
   );

   modport slave (
      input  RS, DATA, CE, RW, FB_READY,
      output DATA_OUT, FB_X, FB_Y, FB_COLOR, FB_WE
   );
endinterface

// File: rtl/rect_walker.sv
// Row-major X/Y walker over a wrapping rectangle: loaded with origin and
// extents (size minus one), advances on step, flags the final pixel.
module rect_walker #(
   parameter int unsigned X_WIDTH = 10,
   parameter int unsigned Y_WIDTH = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [X_WIDTH-1:0] org_x,
   input  logic [Y_WIDTH-1:0] org_y,
   input  logic [X_WIDTH-1:0] ext_w,
   input  logic [Y_WIDTH-1:0] ext_h,
   output logic [X_WIDTH-1:0] cur_x,
   output logic [Y_WIDTH-1:0] cur_y,
   output logic               last
);

   logic [X_WIDTH-1:0] org_x_q;
   logic [X_WIDTH-1:0] ext_w_q;
   logic [Y_WIDTH-1:0] ext_h_q;
   logic [X_WIDTH-1:0] cnt_x_q;
   logic [Y_WIDTH-1:0] cnt_y_q;

   // Offset counters decide row ends; coordinate registers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         org_x_q <= '0;
         ext_w_q <= '0;
         ext_h_q <= '0;
         cnt_x_q <= '0;
         cnt_y_q <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
      end else if (load) begin
         org_x_q <= org_x;
         ext_w_q <= ext_w;
         ext_h_q <= ext_h;
         cnt_x_q <= '0;
         cnt_y_q <= '0;
         cur_x   <= org_x;
         cur_y   <= org_y;
      end else if (step) begin
         if (cnt_x_q == ext_w_q) begin
            cnt_x_q <= '0;
            cur_x   <= org_x_q;
            cnt_y_q <= cnt_y_q + 1'b1;
            cur_y   <= cur_y + 1'b1;
         end else begin
            cnt_x_q <= cnt_x_q + 1'b1;
            cur_x   <= cur_x + 1'b1;
         end
      end
   end

   assign last = (cnt_x_q == ext_w_q) && (cnt_y_q == ext_h_q);

endmodule

// File: rtl/herring_gpu_cmd.sv
// Herring GPU command engine: 6502 register file and status, plus an FSM
// turning PLOT/PLOT_INC/FILL/CLEAR commands into framebuffer pixel writes.
module herring_gpu_cmd
   import herring_gpu_pkg::*;
#(
   parameter int unsigned X_WIDTH     = 10,
   parameter int unsigned Y_WIDTH     = 10,
   parameter int unsigned COLOR_WIDTH = 3
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   herring_gpu_cmd_if.slave  bus
);

   logic [COLOR_WIDTH-1:0] color_q;
   logic [X_WIDTH-1:0]     x_q, x_d;
   logic [Y_WIDTH-1:0]     y_q, y_d;
   logic [7:0]             w_q;
   logic [7:0]             h_q;
   logic                   dropped_q, dropped_d;
   state_t                 state_q, state_d;
   logic                   fb_we_q, fb_we_d;
   logic [COLOR_WIDTH-1:0] eng_color_q;
   logic                   inc_q;

   logic [15:0]            x_ext;
   logic [15:0]            y_ext;
   logic [7:0]             data_out;
   logic                   wr, rd, busy, cmd_ok, start, drop, stat_rd, accept;
   logic                   inc_acc;

   logic                   w_load, w_step, walk_last;
   logic [X_WIDTH-1:0]     org_x, ext_w, walk_x;
   logic [Y_WIDTH-1:0]     org_y, ext_h, walk_y;

   assign wr      = !bus.CE && !bus.RW;
   assign rd      = !bus.CE && bus.RW;
   assign busy    = (state_q != IDLE);
   assign cmd_ok  = wr && (bus.RS == RS_CMD) && is_valid_cmd(bus.DATA);
   assign start   = cmd_ok && !busy;
   assign drop    = cmd_ok && busy;
   assign stat_rd = rd && (bus.RS == RS_CMD);
   assign accept  = fb_we_q && bus.FB_READY;
   assign x_ext   = 16'(x_q);
   assign y_ext   = 16'(y_q);

   // Read mux: combinational from RS so the CPU sees data in the access cycle.
   always_comb begin
      data_out = '0;
      case (bus.RS)
         RS_COLOR: data_out = 8'(color_q);
         RS_X_LO:  data_out = x_ext[7:0];
         RS_X_HI:  data_out = x_ext[15:8];
         RS_Y_LO:  data_out = y_ext[7:0];
         RS_Y_HI:  data_out = y_ext[15:8];
         RS_W:     data_out = w_q;
         RS_H:     data_out = h_q;
         RS_CMD: begin
            data_out[STAT_BUSY]    = busy;
            data_out[STAT_DROPPED] = dropped_q;
         end
         default: ;
      endcase
   end

   assign bus.DATA_OUT = data_out;

   // A drop in the same cycle as a STATUS read wins over the clear.
   always_comb begin
      dropped_d = dropped_q;
      if (drop) begin
         dropped_d = 1'b1;
      end else if (stat_rd) begin
         dropped_d = 1'b0;
      end
   end

   // X/Y next value: PLOT_INC bump first, a CPU write in the same cycle wins.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (inc_acc) begin
         x_d = X_WIDTH'(walk_x + 1'b1);
      end
      if (wr) begin
         case (bus.RS)
            RS_X_LO: x_d = X_WIDTH'({x_ext[15:8], bus.DATA});
            RS_X_HI: x_d = X_WIDTH'({bus.DATA, x_ext[7:0]});
            RS_Y_LO: y_d = Y_WIDTH'({y_ext[15:8], bus.DATA});
            RS_Y_HI: y_d = Y_WIDTH'({bus.DATA, y_ext[7:0]});
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         color_q   <= '0;
         x_q       <= '0;
         y_q       <= '0;
         w_q       <= '0;
         h_q       <= '0;
         dropped_q <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         dropped_q <= dropped_d;
         if (wr && (bus.RS == RS_COLOR)) color_q <= bus.DATA[COLOR_WIDTH-1:0];
         if (wr && (bus.RS == RS_W))     w_q     <= bus.DATA;
         if (wr && (bus.RS == RS_H))     h_q     <= bus.DATA;
      end
   end

   // Engine state, write-valid and per-command latched copies.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         fb_we_q     <= 1'b0;
         eng_color_q <= '0;
         inc_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         fb_we_q <= fb_we_d;
         if (start) begin
            eng_color_q <= color_q;
            inc_q       <= (bus.DATA == CMD_PLOT_INC);
         end
      end
   end

   // Next state and walker control; PLOT uses the walker with zero extents.
   always_comb begin
      state_d = state_q;
      fb_we_d = fb_we_q;
      w_load  = 1'b0;
      w_step  = 1'b0;
      inc_acc = 1'b0;
      org_x   = x_q;
      org_y   = y_q;
      ext_w   = '0;
      ext_h   = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               fb_we_d = 1'b1;
               w_load  = 1'b1;
               case (bus.DATA)
                  CMD_PLOT, CMD_PLOT_INC: state_d = PIXEL;
                  CMD_FILL: begin
                     state_d = WALK;
                     ext_w   = X_WIDTH'(w_q);
                     ext_h   = Y_WIDTH'(h_q);
                  end
                  default: begin
                     state_d = WALK;
                     org_x   = '0;
                     org_y   = '0;
                     ext_w   = '1;
                     ext_h   = '1;
                  end
               endcase
            end
         end
         PIXEL: begin
            if (accept) begin
               state_d = IDLE;
               fb_we_d = 1'b0;
               inc_acc = inc_q;
            end
         end
         WALK: begin
            if (accept) begin
               if (walk_last) begin
                  state_d = IDLE;
                  fb_we_d = 1'b0;
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            fb_we_d = 1'b0;
         end
      endcase
   end

   rect_walker #(
      .X_WIDTH(X_WIDTH),
      .Y_WIDTH(Y_WIDTH)
   ) u_walker (
      .clk   (CLOCK),
      .rst_n (RESET_N),
      .load  (w_load),
      .step  (w_step),
      .org_x (org_x),
      .org_y (org_y),
      .ext_w (ext_w),
      .ext_h (ext_h),
      .cur_x (walk_x),
      .cur_y (walk_y),
      .last  (walk_last)
   );

   assign bus.FB_X     = walk_x;
   assign bus.FB_Y     = walk_y;
   assign bus.FB_COLOR = eng_color_q;
   assign bus.FB_WE    = fb_we_q;

endmodule

// File: doc/herring_gpu_cmd.md
# herring_gpu_cmd

Parametrised command engine for the Herring GPU. It decodes 6502 register writes into framebuffer pixel writes. Beyond single-pixel plots, it adds wide coordinates, configurable colour depth, plot with auto-increment, rectangle fill and full-screen clear, and a readable status register. It sits between the CPU bus decode and the framebuffer write port, in the CPU clock domain. Framebuffer writes use a valid/ready handshake.

## Interface
Parameters:
- X_WIDTH, default 10: framebuffer X coordinate width, legal range 8–16.
- Y_WIDTH, default 10: framebuffer Y coordinate width, legal range 8–16.
- COLOR_WIDTH, default 3: colour bits, legal range 1–8.

Ports:
- CLOCK  in  1: the block's single clock. All state changes on its rising edge.
- RESET_N  in  1: synchronous, active-low reset.
- RS  in  3: register select.
- DATA  in  8: CPU write data.
- CE  in  1: chip enable, active-low. It is a one-cycle strobe, so each cycle it is low is one access.
- RW  in  1: 1 = read, 0 = write.
- DATA_OUT  out  8: read data. Valid in the same cycle as the access, combinational from RS.
- FB_X  out  X_WIDTH: pixel X.
- FB_Y  out  Y_WIDTH: pixel Y.
- FB_COLOR  out  COLOR_WIDTH: pixel colour.
- FB_WE  out  1: pixel write valid.
- FB_READY  in  1: the framebuffer accepts the pixel when FB_WE and FB_READY are both high.

## Operation
Register map (writes happen when CE is low and RW is 0):
- 0 COLOR: stores DATA[COLOR_WIDTH-1:0].
- 1 X_LO, 2 X_HI: together form X. Bits above X_WIDTH are ignored.
- 3 Y_LO, 4 Y_HI: together form Y, same rule.
- 5 W: rectangle width minus 1.
- 6 H: rectangle height minus 1.
- 7 CMD on write; STATUS on read.

Reads of STATUS:
- bit0 = busy, bit1 = dropped. All other bits read 0. Reads of other RS values return the register value, zero-extended.
- A STATUS read clears `dropped`. If a drop occurs in the same cycle, `dropped` stays set.

CMD codes (all other codes are ignored and do not set `dropped`):
- 0x01 PLOT: write one pixel at (X, Y).
- 0x02 PLOT_INC: as PLOT, then X increments by 1, wrapping modulo 2^X_WIDTH. The X register updates when the pixel is accepted.
- 0x03 FILL: fills rectangle X..X+W, Y..Y+H, which is (W+1)·(H+1) pixels. Walk order is row-major, X fastest. Coordinates wrap modulo their width.
- 0x04 CLEAR: writes every (x, y) in 0..2^X_WIDTH−1 × 0..2^Y_WIDTH−1 with COLOR, row-major.

Command start:
- On acceptance, COLOR, X, Y, W and H are latched into engine copies. Later register writes do not disturb the command in progress.

States and transitions:
- IDLE → PIXEL on PLOT or PLOT_INC.
- IDLE → WALK on FILL or CLEAR.
- PIXEL → IDLE when the pixel is accepted.
- WALK → IDLE when the last pixel is accepted.

Boundary rules:
- Busy is 1 whenever the state is not IDLE.
- A CMD write while busy is dropped and sets `dropped`. The current command continues unchanged.
- A register write in the same cycle the engine returns to IDLE is stored normally. A CMD write in that cycle is dropped, because busy is still 1.
- W=0 and H=0 gives exactly 1 pixel.
- A FILL that crosses the edge wraps (X=2^X_WIDTH−1, W=1 writes x = max and x = 0).
- Reset in any state: returns to IDLE, FB_WE is 0, no further pixels are written.

## Timing
Reset values:
- All registers 0.
- FB_WE = 0, FB_X = 0, FB_Y = 0, FB_COLOR = 0.
- dropped = 0, state = IDLE.
- DATA_OUT follows RS over the reset register values.

Latency:
- A CMD written in cycle N asserts FB_WE in cycle N+1.
- With FB_READY held high, FILL issues one pixel per cycle: (W+1)(H+1) cycles of FB_WE, then IDLE on the following cycle.
- Busy reads 1 from cycle N+1 until the cycle after the last acceptance.

Handshake:
- While FB_WE=1 and FB_READY=0, FB_X, FB_Y and FB_COLOR hold stable.
- FB_WE never drops without an acceptance, except at reset.
- The next pixel is presented in the cycle after acceptance; there are no bubbles.

## Structure
- Package `herring_gpu_pkg`: RS address constants, CMD code constants, STATUS bit indices, and the state enum (IDLE, PIXEL, WALK).
- Sub-module `rect_walker`: a parametrised X/Y counter pair. It is loaded with origin and extents, advances on `step`, and flags `last`. CLEAR loads origin (0,0) with extents of all ones.
- The top level holds the bus decode, register file, status logic and FSM.

## Test plan
- Reset, then PLOT with COLOR=5, X=0x123, Y=0x045, FB_READY=1 → exactly one FB_WE cycle at (0x123, 0x045, 5), in cycle N+1. STATUS then reads 0x00.
- PLOT_INC three times from X=0x3FE (X_WIDTH=10) → pixels at X = 0x3FE, 0x3FF, 0x000. The X register reads 1 afterwards.
- FILL with X=0x3FF, Y=2, W=1, H=1 → pixels (0x3FF,2), (0,2), (0x3FF,3), (0,3) in that order. Busy is high for 4 cycles.
- FILL 4×1 with FB_READY toggling 1,0,0,1,… → exactly 4 acceptances, outputs stable while stalled, no duplicates.
- CMD written during FILL → STATUS reads 0x03. A second STATUS read returns 0x01. The fill output is unchanged.
- Reset asserted midway through CLEAR (X_WIDTH=Y_WIDTH=8) → FB_WE is 0 on the next cycle, then IDLE with all registers at 0.
